player_1_ctl: RTL
=================

// Module: player_1_ctl
// PURPOSE
//   Per-frame movement and animation controller for player 1. Converts left/right
//   move requests into a horizontal sprite position and a State (state_pkg) value.
//   Sits directly upstream of the player-1 draw stage, which consumes xpos_player1/state.
//   All updates happen once per video frame, on the rising edge of vsync.
// PARAMETERS
//   X_INIT       12'd380  xpos after reset
//   X_MIN        12'd0    leftmost allowed xpos
//   X_MAX        12'd760  rightmost allowed xpos (800 px line minus 40 px sprite width)
//   STEP         12'd4    pixels moved per frame while walking
//   ANIM_FRAMES  8'd8     frames per walk-animation phase (must be >= 1)
// PORTS
//   clk           in   1   pixel clock
//   rst           in   1   reset: asynchronous assertion, active-low
//   vsync         in   1   vsync from the VGA timing chain; its rising edge = frame tick
//   move_left     in   1   level request: walk left
//   move_right    in   1   level request: walk right
//   xpos_player1  out  12  sprite x offset, registered
//   state         out  State  sprite pose (IDLE/RIGHT1/RIGHT2/LEFT1/LEFT2), registered
// BEHAVIOUR
//   Reset (rst=0, async): xpos_player1=X_INIT, state=IDLE, anim_cnt=0, vsync_d=0.
//   tick = vsync & ~vsync_d (vsync_d = vsync registered). One tick per frame.
//     Outputs update on the clk edge at which tick=1 (1-cycle latency).
//     Without a tick, all outputs and counters hold.
//   req decode on tick: L = move_left & ~move_right; R = move_right & ~move_left.
//     Both high or both low -> none.
//   FSM (evaluated only on tick):
//     none: -> IDLE, anim_cnt=0, xpos held.
//     R from IDLE or LEFTx: -> RIGHT1, anim_cnt=0.
//     L from IDLE or RIGHTx: -> LEFT1, anim_cnt=0.
//     R in RIGHT1/RIGHT2: anim_cnt+1; on reaching ANIM_FRAMES-1 -> toggle RIGHT1<->RIGHT2,
//       and anim_cnt=0. LEFT1/LEFT2 analogous with L.
//   Position (on tick, same edge as state):
//     R: xpos = min(xpos+STEP, X_MAX).
//     L: xpos = max(xpos-STEP, X_MIN).
//     Arithmetic is 13-bit, so xpos+STEP cannot wrap. For L, if xpos < X_MIN+STEP then
//     xpos = X_MIN (no underflow).
//   At a wall the pose still animates and xpos stays clamped.
//   Direction reversal on one tick: xpos moves in the new direction on that same tick.
//   Reset mid-frame: immediate return to reset values. The first tick after release
//     requires a fresh 0->1 vsync edge, because vsync_d restarts at 0. If vsync is already
//     high at release, a tick fires on the first clock.
// CONFIGURATION
//   PLAYER1_SYNC_EN defined: move_left/move_right each pass through a 2-FF synchronizer
//     (reset to 0) before decode. A request must be stable for 2 clk before the tick
//     to be seen.
//   Not defined: the inputs are used directly and are required to be synchronous to clk.
//   Tick and output latency are identical in both builds.
// TESTING
//   1 Reset, vsync toggling, no requests -> xpos=380, state=IDLE held across 5 ticks.
//   2 move_right=1 for 20 ticks -> xpos=460; state RIGHT1 for ticks 1-8, RIGHT2 for 9-16,
//     RIGHT1 for 17-20.
//   3 xpos=758, move_right for 2 ticks -> 760 then 760, state keeps walking.
//     Left wall: xpos=2, move_left -> 0.
//   4 move_right then both high on next tick -> state=IDLE, xpos unchanged,
//     anim_cnt cleared.
//   5 In RIGHT2, switch to move_left -> next tick state=LEFT1, xpos-4.
//   6 rst asserted mid-walk between ticks -> outputs 380/IDLE within the same cycle,
//     no update until the next vsync rise.
//     With PLAYER1_SYNC_EN: a 1-clk request pulse right before the tick is ignored.

Source files
------------

// File: rtl/player_1_ctl.sv
// player_1_ctl: per-frame movement and walk-animation controller for player 1.
// Turns left/right move requests into a clamped horizontal sprite position and a pose.
// Everything advances once per video frame, on the rising edge of vsync.
// Optional build macro: PLAYER1_SYNC_EN adds a 2-FF synchronizer on move_left/move_right.

package state_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RIGHT1 = 3'd1,
        RIGHT2 = 3'd2,
        LEFT1  = 3'd3,
        LEFT2  = 3'd4
    } State;
endpackage

module player_1_ctl #(
    parameter logic [11:0] X_INIT      = 12'd380,
    parameter logic [11:0] X_MIN       = 12'd0,
    parameter logic [11:0] X_MAX       = 12'd760,
    parameter logic [11:0] STEP        = 12'd4,
    parameter logic [7:0]  ANIM_FRAMES = 8'd8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vsync,
    input  logic            move_left,
    input  logic            move_right,
    output logic [11:0]     xpos_player1,
    output state_pkg::State state
);
    import state_pkg::*;

    logic        vsync_q;
    logic        tick;
    logic        left_s;
    logic        right_s;
    logic        req_l;
    logic        req_r;
    logic [12:0] x_sum;
    logic [11:0] right_x;
    logic [11:0] left_x;

    State        state_q;
    State        state_d;
    logic [7:0]  anim_cnt_q;
    logic [7:0]  anim_cnt_d;
    logic [11:0] xpos_q;
    logic [11:0] xpos_d;

`ifdef PLAYER1_SYNC_EN
    logic [1:0] left_sync_q;
    logic [1:0] right_sync_q;

    // Two-stage synchronizers for the move requests, which may come from another clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_sync_q  <= 2'b00;
            right_sync_q <= 2'b00;
        end else begin
            left_sync_q  <= {left_sync_q[0], move_left};
            right_sync_q <= {right_sync_q[0], move_right};
        end
    end

    assign left_s  = left_sync_q[1];
    assign right_s = right_sync_q[1];
`else
    assign left_s  = move_left;
    assign right_s = move_right;
`endif

    // Delayed copy of vsync so its rising edge becomes a one-clock frame tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign tick  = vsync & ~vsync_q;

    // Opposite requests cancel each other out, so only one direction can ever win
    assign req_l = left_s & ~right_s;
    assign req_r = right_s & ~left_s;

    // Candidate positions for a step right or left, clamped to the playfield walls;
    // the sum is one bit wider so a step near the top of the range cannot wrap
    assign x_sum   = {1'b0, xpos_q} + {1'b0, STEP};
    assign right_x = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[11:0];
    assign left_x  = ({1'b0, xpos_q} < ({1'b0, X_MIN} + {1'b0, STEP})) ? X_MIN : (xpos_q - STEP);

    // Next pose, animation counter and position; only a frame tick changes anything
    always_comb begin
        state_d    = state_q;
        anim_cnt_d = anim_cnt_q;
        xpos_d     = xpos_q;
        if (tick) begin
            if (req_r) begin
                xpos_d = right_x;
                if ((state_q == RIGHT1) || (state_q == RIGHT2)) begin
                    if (anim_cnt_q == (ANIM_FRAMES - 8'd1)) begin
                        anim_cnt_d = 8'd0;
                        if (state_q == RIGHT1) begin
                            state_d = RIGHT2;
                        end else begin
                            state_d = RIGHT1;
                        end
                    end else begin
                        anim_cnt_d = anim_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = RIGHT1;
                    anim_cnt_d = 8'd0;
                end
            end else if (req_l) begin
                xpos_d = left_x;
                if ((state_q == LEFT1) || (state_q == LEFT2)) begin
                    if (anim_cnt_q == (ANIM_FRAMES - 8'd1)) begin
                        anim_cnt_d = 8'd0;
                        if (state_q == LEFT1) begin
                            state_d = LEFT2;
                        end else begin
                            state_d = LEFT1;
                        end
                    end else begin
                        anim_cnt_d = anim_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = LEFT1;
                    anim_cnt_d = 8'd0;
                end
            end else begin
                state_d    = IDLE;
                anim_cnt_d = 8'd0;
            end
        end
    end

    // Pose/position register; reset puts the sprite back at its spawn point immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            anim_cnt_q <= 8'd0;
            xpos_q     <= X_INIT;
        end else begin
            state_q    <= state_d;
            anim_cnt_q <= anim_cnt_d;
            xpos_q     <= xpos_d;
        end
    end

    assign xpos_player1 = xpos_q;
    assign state        = state_q;

endmodule
